integer_divider: RTL and testbench

Multi-cycle restoring divider for the 16-bit RISC-V ALU, placed alongside the combinational Multiplication block. The ALU result mux consumes its quotient or remainder for DIV/DIVU/REM/REMU. It accepts one operation at a time through a Start/Busy handshake and runs one quotient bit per clock. Results are registered and held until the next accepted operation.

---
 rtl/integer_divider.sv | 131 +++++++++++++
 tb/tb_integer_divider.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/integer_divider.sv
// Multi-cycle restoring divider (one quotient bit per clock) with RISC-V special-case results.
// Optional DIVIDER_EARLY_OUT_EN: divide-by-zero and signed overflow finish after one CALC cycle.
module integer_divider #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Valid,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero,
  output logic             Overflow
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int              CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] a_raw;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;
  logic             ovf;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             in_div_zero, in_ovf, early_out;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next, dvd_next, q_fix, r_fix;

  // Operand decode at the accepting edge.
  always_comb begin
    a_neg       = Signed & A[WIDTH-1];
    b_neg       = Signed & B[WIDTH-1];
    a_mag       = a_neg ? -A : A;
    b_mag       = b_neg ? -B : B;
    in_div_zero = (B == '0);
    in_ovf      = Signed && (A == MOST_NEG) && (B == '1);
`ifdef DIVIDER_EARLY_OUT_EN
    early_out   = in_div_zero | in_ovf;
`else
    early_out   = 1'b0;
`endif
  end

  // One restoring step: trial subtract in WIDTH+1 bits, keep the difference if non-negative.
  always_comb begin
    trial    = {rem, dvd[WIDTH-1]} - {1'b0, dvs};
    q_bit    = ~trial[WIDTH];
    rem_next = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dvd[WIDTH-1]};
    dvd_next = {dvd[WIDTH-2:0], q_bit};
    q_fix    = q_neg ? -dvd_next : dvd_next;
    r_fix    = r_neg ? -rem_next : rem_next;
  end

  // NOTE: Busy/Valid decode the registered state only, so no input reaches them combinationally.
  assign Busy  = (state != IDLE);
  assign Valid = (state == DONE);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      count     <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      a_raw     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state    <= CALC;
            count    <= early_out ? '0 : LAST_COUNT;
            dvd      <= a_mag;
            dvs      <= b_mag;
            rem      <= '0;
            a_raw    <= A;
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            div_zero <= in_div_zero;
            ovf      <= in_ovf;
          end
        end
        CALC: begin
          dvd   <= dvd_next;
          rem   <= rem_next;
          count <= count - 1'b1;
          if (count == '0) begin
            state     <= DONE;
            DivByZero <= div_zero;
            Overflow  <= ovf;
            if (div_zero) begin
              Quotient  <= '1;
              Remainder <= a_raw;
            end else if (ovf) begin
              Quotient  <= MOST_NEG;
              Remainder <= '0;
            end else begin
              Quotient  <= q_fix;
              Remainder <= r_fix;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_integer_divider.sv
// Self-checking bench for integer_divider: directed, random, ignored-Start, mid-op reset, back-to-back.
module tb_integer_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sgn;
  logic [W-1:0] a, b;
  logic         busy, valid;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero, overflow;

  int n_checks = 0;
  int n_fails  = 0;

  integer_divider #(.WIDTH(W)) dut (
    .Clock(clk), .Reset_n(rst_n), .Start(start), .Signed(sgn), .A(a), .B(b),
    .Busy(busy), .Valid(valid), .Quotient(quotient), .Remainder(remainder),
    .DivByZero(div_by_zero), .Overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division truncating toward zero plus RISC-V special cases.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov);
    int sa, sb;
    dz = 1'b0;
    ov = 1'b0;
    if (mb == 0) begin
      q = '1; r = ma; dz = 1'b1;
    end else if (ms && ma == 16'h8000 && mb == 16'hFFFF) begin
      q = 16'h8000; r = '0; ov = 1'b1;
    end else if (ms) begin
      sa = $signed(ma); sb = $signed(mb);
      q = W'(sa / sb); r = W'(sa % sb);
    end else begin
      sa = {16'h0, ma}; sb = {16'h0, mb};
      q = W'(sa / sb); r = W'(sa % sb);
    end
  endfunction

  function automatic int exp_latency(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
`ifdef DIVIDER_EARLY_OUT_EN
    if (mb == 0 || (ms && ma == 16'h8000 && mb == 16'hFFFF)) return 1;
`endif
    return W;
  endfunction

  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os, input string name);
    logic [W-1:0] eq, er;
    logic edz, eov;
    int vedge, busy_low, lat;
    model(oa, ob, os, eq, er, edz, eov);
    lat = exp_latency(oa, ob, os);
    @(negedge clk);
    a = oa; b = ob; sgn = os; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fails++; $display("FAIL %s busy_at_edge0: got %b want 1", name, busy); end
    vedge = -1; busy_low = 0;
    for (int k = 1; k <= W + 4; k++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin vedge = k; break; end
      if (busy !== 1'b1) busy_low++;
    end
    n_checks++;
    if (vedge != lat) begin n_fails++; $display("FAIL %s valid_edge: got %0d want %0d", name, vedge, lat); end
    n_checks++;
    if (busy_low != 0 || busy !== 1'b1) begin
      n_fails++; $display("FAIL %s busy_during_op: low_cycles %0d busy %b want 0/1", name, busy_low, busy);
    end
    n_checks++;
    if ({quotient, remainder, div_by_zero, overflow} !== {eq, er, edz, eov}) begin
      n_fails++;
      $display("FAIL %s result: got q=%h r=%h dz=%b ov=%b want q=%h r=%h dz=%b ov=%b",
               name, quotient, remainder, div_by_zero, overflow, eq, er, edz, eov);
    end
    @(posedge clk); #1;
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fails++; $display("FAIL %s after_done: got valid=%b busy=%b want 0/0", name, valid, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({quotient, remainder} !== {eq, er}) begin
      n_fails++; $display("FAIL %s hold: got %h/%h want %h/%h", name, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    #12;
    n_checks++;
    if ({busy, valid, quotient, remainder, div_by_zero, overflow} !== '0) begin
      n_fails++; $display("FAIL reset_in: got busy=%b valid=%b q=%h r=%h dz=%b ov=%b want all 0",
                          busy, valid, quotient, remainder, div_by_zero, overflow);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, valid, quotient, remainder, div_by_zero, overflow} !== '0) begin
      n_fails++; $display("FAIL reset_out: got busy=%b valid=%b q=%h r=%h want all 0",
                          busy, valid, quotient, remainder);
    end
  endtask

  task automatic test_directed();
    run_op(16'd100,  16'd7,      1'b0, "u100div7");
    run_op(16'hFFF9, 16'd2,      1'b1, "s_m7div2");
    run_op(16'd7,    16'hFFFE,   1'b1, "s7div_m2");
    run_op(16'd5,    16'd0,      1'b0, "u5div0");
    run_op(16'hFFF9, 16'd0,      1'b1, "s_m7div0");
    run_op(16'h8000, 16'hFFFF,   1'b1, "s_ovf");
    run_op(16'h8000, 16'hFFFF,   1'b0, "u8000divffff");
    run_op(16'hFFFF, 16'd1,      1'b0, "uffffdiv1");
    run_op(16'h8000, 16'd1,      1'b1, "s_minneg_div1");
    run_op(16'd3,    16'd10,     1'b0, "u_small_div_big");
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic rs;
    int mode;
    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 9);
      if (mode == 0) rb = '0;
      else if (mode == 1) begin ra = 16'h8000; rb = 16'hFFFF; rs = 1'b1; end
      else if (mode == 2) rb = W'($urandom_range(1, 9));
      run_op(ra, rb, rs, "random");
    end
  endtask

  task automatic test_ignore_start();
    int vcount, vedge;
    logic [W-1:0] gq, gr;
    @(negedge clk);
    a = 16'd100; b = 16'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vcount = 0; vedge = -1; gq = '0; gr = '0;
    for (int k = 1; k <= W + 8; k++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin vcount++; vedge = k; gq = quotient; gr = remainder; end
      if (k == 4) begin a = 16'd9; b = 16'd3; start = 1'b1; end
      if (k == 5) start = 1'b0;
    end
    n_checks++;
    if (vcount != 1) begin n_fails++; $display("FAIL ignore_start valid_count: got %0d want 1", vcount); end
    n_checks++;
    if (vedge != W) begin n_fails++; $display("FAIL ignore_start valid_edge: got %0d want %0d", vedge, W); end
    n_checks++;
    if ({gq, gr} !== {16'd14, 16'd2}) begin
      n_fails++; $display("FAIL ignore_start result: got %h/%h want 000e/0002", gq, gr);
    end
  endtask

  task automatic test_mid_reset();
    int vcount;
    @(negedge clk);
    a = 16'd300; b = 16'd11; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, valid, quotient, remainder, div_by_zero, overflow} !== '0) begin
      n_fails++; $display("FAIL mid_reset: got busy=%b valid=%b q=%h r=%h dz=%b ov=%b want all 0",
                          busy, valid, quotient, remainder, div_by_zero, overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk); #1;
      if (valid !== 1'b0 || busy !== 1'b0) vcount++;
    end
    n_checks++;
    if (vcount != 0) begin n_fails++; $display("FAIL mid_reset no_valid: got %0d active cycles want 0", vcount); end
    run_op(16'd1000, 16'd33, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int vedges[$];
    logic [W-1:0] qs[$], rs[$];
    logic [W-1:0] q1, r1, q2, r2;
    logic d1, o1, d2, o2;
    model(16'd5000, 16'd13,   1'b0, q1, r1, d1, o1);
    model(16'hFF00, 16'd7,    1'b1, q2, r2, d2, o2);
    @(negedge clk);
    a = 16'd5000; b = 16'd13; sgn = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'hFF00; b = 16'd7; sgn = 1'b1;
    for (int k = 1; k <= 2 * W + 6; k++) begin
      @(posedge clk); #1;
      if (k == W + 2) start = 1'b0;
      if (valid === 1'b1) begin vedges.push_back(k); qs.push_back(quotient); rs.push_back(remainder); end
    end
    n_checks++;
    if (vedges.size() != 2) begin
      n_fails++; $display("FAIL b2b count: got %0d want 2", vedges.size());
    end else begin
      n_checks++;
      if (vedges[0] != W || vedges[1] != 2 * W + 2) begin
        n_fails++; $display("FAIL b2b edges: got %0d,%0d want %0d,%0d", vedges[0], vedges[1], W, 2 * W + 2);
      end
      n_checks++;
      if ({qs[0], rs[0], qs[1], rs[1]} !== {q1, r1, q2, r2}) begin
        n_fails++; $display("FAIL b2b results: got %h/%h %h/%h want %h/%h %h/%h",
                            qs[0], rs[0], qs[1], rs[1], q1, r1, q2, r2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
